ddot_pack8: RTL and testbench
=============================

# ddot_pack8

Input packer for the 8-lane FP32 dot-product datapath. It accepts a scalar stream of (x, y) FP32 element pairs with a valid/ready handshake and assembles them into 8-wide lane blocks. Short final blocks are zero-padded. Each block is presented on the x0..x7 / y0..y7 / ready inputs of ddot_fsmd, so it sits directly upstream of that block. A one-block output slot, backed by a stall input, decouples element arrival from block issue.

## Interface
- LANES, 8: lanes per block; fixed at 8, range-checked.
- W, 32: element width (IEEE-754 single).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  element pair present.
- s_x  in  W  x element.
- s_y  in  W  y element.
- s_last  in  1  final element of the current vector.
- s_ready  out  1  packer can accept an element this cycle.
- dot_busy  in  1  downstream cannot take a block this cycle.
- ready  out  1  one-cycle issue strobe; wires to ddot_fsmd.ready.
- x0..x7, y0..y7  out  W each  issued block lanes.
- last  out  1  issued block ends a vector; valid while ready=1.
- nlanes  out  4  count of real (unpadded) lanes, 1..8; valid while ready=1.

## Operation
- Two storage levels:
  - pack register: 8 x/y lane pairs, 3-bit write index cnt, flag pack_full.
  - out slot: 8 x/y lane pairs plus last/nlanes, flag out_full.
- Accept condition: s_valid && s_ready, with s_ready = !pack_full. On accept, write s_x/s_y to lane cnt.
- Block complete when the accepted element has cnt==7 or s_last=1.
  - On completion, zero lanes above cnt (32'h0 = +0.0), record nlanes=cnt+1 and last=s_last, reset cnt to 0.
  - s_last with cnt==7 gives nlanes=8 and no padding; no extra empty block is generated.
- Transfer pack→out at the same edge when the out slot is empty or is issuing this cycle. Otherwise set pack_full; s_ready stays low until the transfer happens.
- Issue: ready=1 in any cycle with out_full && !dot_busy. At that edge out_full clears, unless a transfer refills the slot at the same edge.
- Output lane registers hold their last issued values between strobes and are not cleared after issue.
- FSM states: FILL (pack accepting), HOLD (pack_full, waiting on the out slot). The out slot is tracked by its own flag.
- Reset, asynchronous and any time including mid-block:
  - cnt=0, pack_full=0, out_full=0, ready=0, last=0, nlanes=0.
  - All x*/y* outputs = 0. s_ready = 1 once rst deasserts.
  - Any partial block is discarded.

## Timing
- Latency: the edge that accepts the completing element loads the out slot. ready is high in the next cycle if dot_busy=0.
- Throughput: 1 element/cycle sustained; one block per 8 cycles with no s_ready bubble while dot_busy=0.
- dot_busy is sampled combinationally in the issue cycle. ready never asserts while dot_busy=1.
- Buffering: with dot_busy high, up to 2 blocks are held (out + pack). The 2nd completing element is accepted, then s_ready drops the next cycle.
- Simultaneous issue and pack completion in one cycle: both happen. The out slot reloads and ready may assert in consecutive cycles.
- No combinational path from s_valid to s_ready.

## Structure
- Shared package ddot_pkg: W, LANES, FP32_ZERO constant, and the FSM state enum (FILL, HOLD), both reused by ddot_fsmd and the downstream accumulator.
- One sub-module, ddot_lane_bank: an 8x(2W) register bank with indexed write, pad-above-index clear, and parallel read. It is instantiated twice, for pack and out.

## Test plan
- Full block: reset, then 8 pairs of 3f800000 with s_last on the 8th. Expected: x0..y7 all 3f800000, ready=1 for exactly 1 cycle after the 8th accept, nlanes=8, last=1, no padding block.
- Back-to-back: 16 pairs, x=40000000, y=3f800000, s_valid held high. Expected: s_ready never drops, two ready pulses 8 cycles apart, first block last=0, second block last=1.
- Short vector: 3 pairs with s_last on the 3rd. Expected: x0..x2/y0..y2 carry the data, x3..x7/y3..y7 = 0, nlanes=3, last=1.
- Backpressure: dot_busy=1 while 16 pairs are offered. Expected: s_ready drops the cycle after the 16th accept and no ready pulse occurs. Releasing dot_busy gives two ready pulses on consecutive cycles, in order, and s_ready reasserts.
- Reset mid-block: assert rst after 5 accepts. Expected: all outputs 0 and ready=0 immediately. After rst deasserts, 8 new pairs issue with lane 0 = the first new pair.
- Issue/complete collision: hold dot_busy until pack_full, then release it in the same cycle the pack is full. Expected: the pending block issues, the pack transfers, and the next ready follows in the next cycle with correct data.

Source files
------------

// File: rtl/ddot_pkg.sv
// ddot_pkg: constants and types shared by the dot-product datapath blocks
// (ddot_pack8, ddot_fsmd, downstream accumulator).
//   W         element width (IEEE-754 single)
//   LANES     lanes per block
//   FP32_ZERO +0.0, used for padding short blocks
//   pack_state_e  packer FSM states (FILL, HOLD)
//   blk_meta_t    per-block sideband (last, nlanes)
package ddot_pkg;
  localparam int W     = 32;
  localparam int LANES = 8;
  localparam int IDX_W = $clog2(LANES);
  localparam int NL_W  = IDX_W + 1;

  localparam logic [W-1:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic {
    FILL = 1'b0,   // pack register accepting elements
    HOLD = 1'b1    // pack register full, waiting for the out slot
  } pack_state_e;

  typedef struct packed {
    logic            last;
    logic [NL_W-1:0] nlanes;
  } blk_meta_t;

  // Real lane count of a block whose final element landed at lane idx.
  function automatic logic [NL_W-1:0] lanes_used(input logic [IDX_W-1:0] idx);
    return NL_W'(idx) + NL_W'(1);
  endfunction
endpackage

// File: rtl/ddot_pack8_if.sv
// ddot_pack8_if: element stream in, lane block out.
//   s_valid/s_x/s_y/s_last/s_ready  scalar (x, y) element stream
//   dot_busy                        downstream stall
//   ready                           one-cycle block issue strobe
//   x0..x7, y0..y7, last, nlanes    issued block
// slave = packer side, master = source/sink side.
interface ddot_pack8_if;
  import ddot_pkg::*;

  logic         s_valid;
  logic [W-1:0] s_x;
  logic [W-1:0] s_y;
  logic         s_last;
  logic         s_ready;
  logic         dot_busy;
  logic         ready;
  logic [W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic         last;
  logic [3:0]   nlanes;

  modport slave (
    input  s_valid, s_x, s_y, s_last, dot_busy,
    output s_ready, ready, last, nlanes,
    output x0, x1, x2, x3, x4, x5, x6, x7,
    output y0, y1, y2, y3, y4, y5, y6, y7
  );

  modport master (
    output s_valid, s_x, s_y, s_last, dot_busy,
    input  s_ready, ready, last, nlanes,
    input  x0, x1, x2, x3, x4, x5, x6, x7,
    input  y0, y1, y2, y3, y4, y5, y6, y7
  );
endinterface

// File: rtl/ddot_lane_bank.sv
// ddot_lane_bank: N x DW register bank.
//   clk, rst     clock, async active-low reset (clears all lanes)
//   i_ld         parallel load of all lanes from i_ld_data (wins over i_we)
//   i_we/i_idx   write i_wdata to lane i_idx
//   i_pad        with i_we: also clear every lane above i_idx (+0.0)
//   o_rd         parallel read; shows the pending indexed write/pad so a
//                completing block can be forwarded in the same cycle.
//                With i_we=0 it is simply the stored contents.
module ddot_lane_bank
  import ddot_pkg::*;
#(
  parameter int N  = LANES,
  parameter int DW = 2*W,
  parameter int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ld,
  input  logic [N-1:0][DW-1:0] i_ld_data,
  input  logic                 i_we,
  input  logic [IW-1:0]        i_idx,
  input  logic [DW-1:0]        i_wdata,
  input  logic                 i_pad,
  output logic [N-1:0][DW-1:0] o_rd
);
  logic [N-1:0][DW-1:0] r_q;

  always_comb begin
    o_rd = r_q;
    if (i_we) begin
      for (int i = 0; i < N; i++) begin
        if (i_idx == IW'(i))
          o_rd[i] = i_wdata;
        else if (i_pad && (IW'(i) > i_idx))
          o_rd[i] = '0;           // +0.0 in both halves
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_q <= '0;
    else if (i_ld)
      r_q <= i_ld_data;
    else if (i_we)
      r_q <= o_rd;
  end
endmodule

// File: rtl/ddot_pack8.sv
// ddot_pack8: packs a scalar (x, y) FP32 stream into 8-lane blocks for
// ddot_fsmd. Short final blocks are zero-padded.
//   clk   rising-edge clock
//   rst   async active-low reset; discards any partial block
//   bus   ddot_pack8_if.slave: element stream in, block out
// Two levels: a pack bank being filled and an out slot being offered.
// A completing element is forwarded straight into the out slot when the
// slot is free (or issuing this cycle); otherwise the pack bank holds it
// and s_ready drops until the slot frees up.
module ddot_pack8
  import ddot_pkg::*;
#(
  parameter int NUM_LANES = LANES
) (
  input  logic          clk,
  input  logic          rst,
  ddot_pack8_if.slave   bus
);
  if (NUM_LANES != 8) begin : g_lanes_chk
    $error("ddot_pack8: NUM_LANES must be 8");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES-1);

  pack_state_e                r_state;
  logic [IDX_W-1:0]           r_cnt;
  logic                       r_out_full;
  blk_meta_t                  r_pk_meta;
  blk_meta_t                  r_out_meta;

  logic [LANES-1:0][2*W-1:0]  w_pk_rd;
  logic [LANES-1:0][2*W-1:0]  w_out_rd;
  logic                       w_accept;
  logic                       w_complete;
  logic                       w_issue;
  logic                       w_slot_free;
  logic                       w_xfer_fill;
  logic                       w_xfer_hold;
  logic                       w_out_ld;
  blk_meta_t                  w_new_meta;

  assign w_accept    = bus.s_valid && (r_state == FILL);
  assign w_complete  = w_accept && (bus.s_last || (r_cnt == LAST_IDX));
  assign w_issue     = r_out_full && !bus.dot_busy;
  // Slot can take a block if empty or emptying at this edge.
  assign w_slot_free = !r_out_full || w_issue;
  assign w_xfer_fill = w_complete && w_slot_free;
  assign w_xfer_hold = (r_state == HOLD) && w_slot_free;
  assign w_out_ld    = w_xfer_fill || w_xfer_hold;
  assign w_new_meta  = '{last: bus.s_last, nlanes: lanes_used(r_cnt)};

  // Pack bank: pad only on the completing element. In HOLD no write is
  // pending, so w_pk_rd is the held block; in FILL it is the merged
  // block including the element being accepted.
  ddot_lane_bank #(.N(LANES), .DW(2*W)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .i_ld      (1'b0),
    .i_ld_data ('0),
    .i_we      (w_accept),
    .i_idx     (r_cnt),
    .i_wdata   ({bus.s_x, bus.s_y}),
    .i_pad     (w_complete),
    .o_rd      (w_pk_rd)
  );

  // Out slot: loaded whole; lanes hold after issue.
  ddot_lane_bank #(.N(LANES), .DW(2*W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .i_ld      (w_out_ld),
    .i_ld_data (w_pk_rd),
    .i_we      (1'b0),
    .i_idx     ('0),
    .i_wdata   ('0),
    .i_pad     (1'b0),
    .o_rd      (w_out_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FILL;
      r_cnt      <= '0;
      r_out_full <= 1'b0;
      r_pk_meta  <= '0;
      r_out_meta <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_complete) begin
              r_cnt <= '0;
              if (!w_slot_free) begin
                r_pk_meta <= w_new_meta;
                r_state   <= HOLD;
              end
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        HOLD: if (w_slot_free) r_state <= FILL;
        default: r_state <= FILL;
      endcase

      // A reload at the issue edge keeps the slot full.
      if (w_out_ld) begin
        r_out_full <= 1'b1;
        r_out_meta <= w_xfer_fill ? w_new_meta : r_pk_meta;
      end else if (w_issue) begin
        r_out_full <= 1'b0;
      end
    end
  end

  assign bus.s_ready = (r_state == FILL);
  assign bus.ready   = w_issue;
  assign bus.last    = r_out_meta.last;
  assign bus.nlanes  = r_out_meta.nlanes;

  assign bus.x0 = w_out_rd[0][2*W-1:W];  assign bus.y0 = w_out_rd[0][W-1:0];
  assign bus.x1 = w_out_rd[1][2*W-1:W];  assign bus.y1 = w_out_rd[1][W-1:0];
  assign bus.x2 = w_out_rd[2][2*W-1:W];  assign bus.y2 = w_out_rd[2][W-1:0];
  assign bus.x3 = w_out_rd[3][2*W-1:W];  assign bus.y3 = w_out_rd[3][W-1:0];
  assign bus.x4 = w_out_rd[4][2*W-1:W];  assign bus.y4 = w_out_rd[4][W-1:0];
  assign bus.x5 = w_out_rd[5][2*W-1:W];  assign bus.y5 = w_out_rd[5][W-1:0];
  assign bus.x6 = w_out_rd[6][2*W-1:W];  assign bus.y6 = w_out_rd[6][W-1:0];
  assign bus.x7 = w_out_rd[7][2*W-1:W];  assign bus.y7 = w_out_rd[7][W-1:0];
endmodule

// File: tb/tb_ddot_pack8.sv
// Scoreboard bench for ddot_pack8: stimulus pushes expected blocks,
// a negedge monitor pops and compares on every ready strobe.
module tb_ddot_pack8;
  import ddot_pkg::*;

  typedef struct packed {
    logic [7:0][31:0] x;
    logic [7:0][31:0] y;
    logic             last;
    logic [3:0]       nl;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddot_pack8_if bus();
  ddot_pack8 dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   stalls = 0;
  int   npulse = 0;
  blk_t exp_q[$];
  int   pcyc[$];
  blk_t cur;
  int   cur_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic blk_t dut_blk();
    blk_t b;
    b.x    = {bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
    b.y    = {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
    b.last = bus.last;
    b.nl   = bus.nlanes;
    return b;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    blk_t a, e;
    if (rst && bus.ready) begin
      a = dut_blk();
      npulse++;
      pcyc.push_back(cyc);
      chk("ready_while_busy", 256'(bus.dot_busy), 256'(0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block got x=%h want none", a.x);
      end else begin
        e = exp_q.pop_front();
        chk("blk_x", a.x, e.x);
        chk("blk_y", a.y, e.y);
        chk("blk_last", 256'(a.last), 256'(e.last));
        chk("blk_nlanes", 256'(a.nl), 256'(e.nl));
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic l);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_x     = x;
    bus.s_y     = y;
    bus.s_last  = l;
    forever begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk);
        break;
      end
      stalls++;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got no s_ready want s_ready within 200 cycles");
        @(posedge clk);
        break;
      end
      @(posedge clk);
    end
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Expected block = accepted lanes, zero above, nlanes = lanes used.
  task automatic put(input logic [31:0] x, input logic [31:0] y, input logic l);
    cur.x[cur_n] = x;
    cur.y[cur_n] = y;
    cur_n++;
    if (l || cur_n == 8) begin
      cur.last = l;
      cur.nl   = 4'(cur_n);
      exp_q.push_back(cur);
      cur   = '0;
      cur_n = 0;
    end
    send(x, y, l);
  endtask

  function automatic int pulse_gap();
    int s = pcyc.size();
    if (s < 2) return -1;
    return pcyc[s-1] - pcyc[s-2];
  endfunction

  initial begin
    blk_t r;
    cur   = '0;
    cur_n = 0;
    bus.s_valid  = 1'b0;
    bus.s_x      = '0;
    bus.s_y      = '0;
    bus.s_last   = 1'b0;
    bus.dot_busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    r = dut_blk();
    chk("rst_s_ready", 256'(bus.s_ready), 256'(1));
    chk("rst_ready", 256'(bus.ready), 256'(0));
    chk("rst_x", r.x, 256'(0));
    chk("rst_y", r.y, 256'(0));
    chk("rst_last_nlanes", 256'({r.last, r.nl}), 256'(0));
    @(posedge clk); #1;

    // Full block: 8 x 1.0, last on 8th
    for (int i = 0; i < 8; i++) put(32'h3f800000, 32'h3f800000, i == 7);
    @(negedge clk);
    chk("full_ready_hi", 256'(bus.ready), 256'(1));
    @(negedge clk);
    chk("full_ready_lo", 256'(bus.ready), 256'(0));
    repeat (4) @(negedge clk);
    chk("full_no_pad_blk", 256'(npulse), 256'(1));
    @(posedge clk); #1;

    // Back-to-back 16 pairs
    stalls = 0;
    for (int i = 0; i < 16; i++) put(32'h40000000, 32'h3f800000, i == 15);
    repeat (3) @(negedge clk);
    chk("b2b_no_stall", 256'(stalls), 256'(0));
    chk("b2b_gap", 256'(pulse_gap()), 256'(8));
    chk("b2b_pulses", 256'(npulse), 256'(3));
    @(posedge clk); #1;

    // Short vector, 3 lanes
    put(32'h3f800000, 32'h40800000, 1'b0);
    put(32'h40000000, 32'h40a00000, 1'b0);
    put(32'h40400000, 32'h40c00000, 1'b1);
    repeat (3) @(negedge clk);
    chk("short_pulses", 256'(npulse), 256'(4));
    @(posedge clk); #1;

    // Backpressure: two blocks buffered under dot_busy
    bus.dot_busy = 1'b1;
    stalls = 0;
    for (int i = 0; i < 16; i++) put(32'h41000000 + i, 32'h42000000 + i, i == 15);
    chk("bp_no_stall", 256'(stalls), 256'(0));
    @(negedge clk);
    chk("bp_s_ready_lo", 256'(bus.s_ready), 256'(0));
    repeat (3) @(negedge clk);
    chk("bp_s_ready_held", 256'(bus.s_ready), 256'(0));
    chk("bp_no_issue", 256'(npulse), 256'(4));
    @(posedge clk); #1;
    bus.dot_busy = 1'b0;
    @(negedge clk);
    chk("bp_rel_ready1", 256'(bus.ready), 256'(1));
    @(negedge clk);
    chk("bp_rel_ready2", 256'(bus.ready), 256'(1));
    chk("bp_s_ready_back", 256'(bus.s_ready), 256'(1));
    @(negedge clk);
    chk("bp_ready_done", 256'(bus.ready), 256'(0));
    chk("bp_gap", 256'(pulse_gap()), 256'(1));
    @(posedge clk); #1;

    // Reset mid-block after 5 accepts
    for (int i = 0; i < 5; i++) put(32'h3d000000 + i, 32'h3c000000 + i, 1'b0);
    rst = 1'b0;
    #1;
    r = dut_blk();
    chk("mid_rst_ready", 256'(bus.ready), 256'(0));
    chk("mid_rst_x", r.x, 256'(0));
    chk("mid_rst_y", r.y, 256'(0));
    chk("mid_rst_last_nlanes", 256'({r.last, r.nl}), 256'(0));
    cur   = '0;
    cur_n = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) put(32'h3e000000 + i, 32'h3f000000 + i, i == 7);
    repeat (3) @(negedge clk);
    chk("post_rst_pulses", 256'(npulse), 256'(7));
    @(posedge clk); #1;

    // Issue and completion at the same edge
    bus.dot_busy = 1'b1;
    for (int i = 0; i < 8; i++) put(32'h43000000 + i, 32'h44000000 + i, 1'b0);
    for (int i = 0; i < 7; i++) put(32'h45000000 + i, 32'h46000000 + i, 1'b0);
    bus.dot_busy = 1'b0;
    put(32'h45000007, 32'h46000007, 1'b1);
    @(negedge clk);
    chk("coll_ready_next", 256'(bus.ready), 256'(1));
    @(negedge clk);
    chk("coll_gap", 256'(pulse_gap()), 256'(1));
    chk("coll_pulses", 256'(npulse), 256'(9));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
